// File: rtl/pcm_capture_sequencer_if.sv
// Handshake/bus bundle between the PCM capture sequencer and its detectors/consumer.
// slave modport is the sequencer's view; master is the driver/consumer view.
interface pcm_capture_sequencer_if #(
  parameter int NUM_CH = 3
);
  logic                   start;
  logic [NUM_CH-1:0]      ch_triggered;
  logic [32*NUM_CH-1:0]   ch_time;
  logic                   result_ack;
  logic [31:0]            sample_counter;
  logic                   det_reset;
  logic                   busy;
  logic                   result_valid;
  logic [NUM_CH-1:0]      result_mask;
  logic [7:0]             result_first;
  logic [32*NUM_CH-1:0]   result_delta;

  modport slave (
    input  start, ch_triggered, ch_time, result_ack,
    output sample_counter, det_reset, busy, result_valid,
           result_mask, result_first, result_delta
  );

  modport master (
    output start, ch_triggered, ch_time, result_ack,
    input  sample_counter, det_reset, busy, result_valid,
           result_mask, result_first, result_delta
  );
endinterface

// File: rtl/pcm_capture_sequencer.sv
// Sequences NUM_CH peak detectors: arm, capture window, report earliest channel and deltas, hold-off.
// Define PCM_SEQ_AUTO_REARM_EN to return to ARMED (instead of IDLE) when hold-off ends.
module pcm_capture_sequencer #(
  parameter int NUM_CH      = 3,
  parameter int WINDOW_LEN  = 4800,
  parameter int HOLDOFF_LEN = 24000
) (
  input  logic                   pcm_clk,
  input  logic                   reset,
  pcm_capture_sequencer_if.slave bus
);

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_ARMED   = 3'd1,
    ST_WINDOW  = 3'd2,
    ST_REPORT  = 3'd3,
    ST_HOLDOFF = 3'd4
  } state_t;

  localparam logic [15:0] WINDOW_LAST  = 16'(WINDOW_LEN - 1);
  localparam logic [15:0] HOLDOFF_LAST = 16'(HOLDOFF_LEN - 1);

  state_t                 state_r;
  state_t                 next_state_s;
  logic [15:0]            cnt_r;
  logic [15:0]            next_cnt_s;
  logic                   capture_s;
  logic                   ack_s;

  logic [31:0]            sample_counter_r;
  logic                   det_reset_r;
  logic                   busy_r;
  logic                   result_valid_r;
  logic [NUM_CH-1:0]      result_mask_r;
  logic [7:0]             result_first_r;
  logic [32*NUM_CH-1:0]   result_delta_r;

  logic                   found_s;
  logic [7:0]             first_idx_s;
  logic [31:0]            first_time_s;
  logic [32*NUM_CH-1:0]   delta_s;

  // Wrap-safe ordering: t_a precedes t_b when the signed difference is negative.
  function automatic logic is_earlier(input logic [31:0] t_a, input logic [31:0] t_b);
    logic [31:0] diff;
    diff = t_a - t_b;
    return diff[31];
  endfunction

  // Next-state and phase-counter logic.
  always_comb begin
    next_state_s = state_r;
    next_cnt_s   = cnt_r;
    capture_s    = 1'b0;
    ack_s        = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (bus.start) begin
          next_state_s = ST_ARMED;
          next_cnt_s   = 16'd0;
        end else begin
          next_state_s = ST_IDLE;
        end
      end
      ST_ARMED: begin
        if (|bus.ch_triggered) begin
          next_state_s = ST_WINDOW;
          next_cnt_s   = 16'd0;
        end else begin
          next_state_s = ST_ARMED;
        end
      end
      ST_WINDOW: begin
        if (cnt_r == WINDOW_LAST) begin
          next_state_s = ST_REPORT;
          next_cnt_s   = 16'd0;
          capture_s    = 1'b1;
        end else begin
          next_cnt_s   = cnt_r + 16'd1;
        end
      end
      ST_REPORT: begin
        if (bus.result_ack) begin
          next_state_s = ST_HOLDOFF;
          next_cnt_s   = 16'd0;
          ack_s        = 1'b1;
        end else begin
          next_state_s = ST_REPORT;
        end
      end
      ST_HOLDOFF: begin
        if (cnt_r == HOLDOFF_LAST) begin
`ifdef PCM_SEQ_AUTO_REARM_EN
          next_state_s = ST_ARMED;
`else
          next_state_s = ST_IDLE;
`endif
          next_cnt_s   = 16'd0;
        end else begin
          next_cnt_s   = cnt_r + 16'd1;
        end
      end
      default: begin
        next_state_s = ST_IDLE;
        next_cnt_s   = 16'd0;
      end
    endcase
  end

  // Earliest triggered channel and per-channel deltas, evaluated on the live inputs at capture.
  always_comb begin
    found_s      = 1'b0;
    first_idx_s  = 8'd0;
    first_time_s = 32'd0;
    delta_s      = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (bus.ch_triggered[i] && (!found_s || is_earlier(bus.ch_time[32*i +: 32], first_time_s))) begin
        found_s      = 1'b1;
        first_idx_s  = 8'(i);
        first_time_s = bus.ch_time[32*i +: 32];
      end else begin
        found_s      = found_s;
      end
    end
    for (int i = 0; i < NUM_CH; i++) begin
      if (bus.ch_triggered[i]) begin
        delta_s[32*i +: 32] = bus.ch_time[32*i +: 32] - first_time_s;
      end else begin
        delta_s[32*i +: 32] = 32'd0;
      end
    end
  end

  // State, counters and all registered outputs.
  always_ff @(posedge pcm_clk) begin
    if (reset) begin
      state_r          <= ST_IDLE;
      cnt_r            <= 16'd0;
      sample_counter_r <= 32'd0;
      det_reset_r      <= 1'b1;
      busy_r           <= 1'b0;
      result_valid_r   <= 1'b0;
      result_mask_r    <= '0;
      result_first_r   <= 8'd0;
      result_delta_r   <= '0;
    end else begin
      state_r          <= next_state_s;
      cnt_r            <= next_cnt_s;
      sample_counter_r <= sample_counter_r + 32'd1;
      det_reset_r      <= (next_state_s != ST_ARMED) && (next_state_s != ST_WINDOW);
      busy_r           <= (next_state_s != ST_IDLE);
      if (capture_s) begin
        result_valid_r <= 1'b1;
        result_mask_r  <= bus.ch_triggered;
        result_first_r <= first_idx_s;
        result_delta_r <= delta_s;
      end else if (ack_s) begin
        result_valid_r <= 1'b0;
      end else begin
        result_valid_r <= result_valid_r;
      end
    end
  end

  assign bus.sample_counter = sample_counter_r;
  assign bus.det_reset      = det_reset_r;
  assign bus.busy           = busy_r;
  assign bus.result_valid   = result_valid_r;
  assign bus.result_mask    = result_mask_r;
  assign bus.result_first   = result_first_r;
  assign bus.result_delta   = result_delta_r;

endmodule

// File: tb/tb_pcm_capture_sequencer.sv
// Directed, table-driven bench for pcm_capture_sequencer (NUM_CH=3, WINDOW_LEN=8, HOLDOFF_LEN=4).
module tb_pcm_capture_sequencer;
  localparam int NUM_CH = 3;

  logic pcm_clk = 1'b0;
  logic reset;
  int   n_checks = 0;
  int   n_fail   = 0;
  logic model_armed = 1'b0;

  pcm_capture_sequencer_if #(.NUM_CH(NUM_CH)) bus ();

  pcm_capture_sequencer #(
    .NUM_CH(NUM_CH),
    .WINDOW_LEN(8),
    .HOLDOFF_LEN(4)
  ) dut (
    .pcm_clk(pcm_clk),
    .reset(reset),
    .bus(bus)
  );

  always #5 pcm_clk = ~pcm_clk;

  typedef struct {
    logic [2:0]  mask;
    logic [31:0] t0, t1, t2;
    logic [7:0]  first;
    logic [31:0] d0, d1, d2;
    int          hold;
  } vec_t;

  vec_t vecs[6];

  task automatic step(input int n = 1);
    for (int k = 0; k < n; k++) begin
      @(posedge pcm_clk);
      #1;
    end
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic check_result(input vec_t v, input string tag);
    check({tag, "_valid"}, {31'd0, bus.result_valid}, 32'd1);
    check({tag, "_detrst"}, {31'd0, bus.det_reset}, 32'd1);
    check({tag, "_mask"}, {29'd0, bus.result_mask}, {29'd0, v.mask});
    check({tag, "_first"}, {24'd0, bus.result_first}, {24'd0, v.first});
    check({tag, "_d0"}, bus.result_delta[31:0], v.d0);
    check({tag, "_d1"}, bus.result_delta[63:32], v.d1);
    check({tag, "_d2"}, bus.result_delta[95:64], v.d2);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_cnt"}, bus.sample_counter, 32'd0);
    check({tag, "_detrst"}, {31'd0, bus.det_reset}, 32'd1);
    check({tag, "_busy"}, {31'd0, bus.busy}, 32'd0);
    check({tag, "_valid"}, {31'd0, bus.result_valid}, 32'd0);
    check({tag, "_mask"}, {29'd0, bus.result_mask}, 32'd0);
    check({tag, "_first"}, {24'd0, bus.result_first}, 32'd0);
    check({tag, "_delta"}, {31'd0, |bus.result_delta}, 32'd0);
  endtask

  task automatic run_vector(input vec_t v, input int idx);
    string tag;
    tag = $sformatf("v%0d", idx);
    if (!model_armed) begin
      check({tag, "_idle_busy"}, {31'd0, bus.busy}, 32'd0);
      bus.start = 1'b1;
      step();
      bus.start = 1'b0;
    end
    check({tag, "_armed_busy"}, {31'd0, bus.busy}, 32'd1);
    check({tag, "_armed_detrst"}, {31'd0, bus.det_reset}, 32'd0);
    // ack outside REPORT must have no effect
    bus.result_ack = 1'b1;
    step(2);
    bus.result_ack = 1'b0;
    check({tag, "_armed_valid"}, {31'd0, bus.result_valid}, 32'd0);
    bus.ch_time      = {v.t2, v.t1, v.t0};
    bus.ch_triggered = v.mask;
    step(8);
    check({tag, "_win_valid"}, {31'd0, bus.result_valid}, 32'd0);
    check({tag, "_win_detrst"}, {31'd0, bus.det_reset}, 32'd0);
    step();
    check_result(v, {tag, "_rep"});
    bus.ch_triggered = 3'd0;
    bus.ch_time      = '0;
    for (int c = 0; c < v.hold; c++) begin
      bus.start = (c == 3);
      step();
      check_result(v, {tag, "_hold"});
    end
    bus.start      = 1'b0;
    bus.result_ack = 1'b1;
    step();
    bus.result_ack = 1'b0;
    check({tag, "_ho_valid"}, {31'd0, bus.result_valid}, 32'd0);
    check({tag, "_ho_detrst"}, {31'd0, bus.det_reset}, 32'd1);
    check({tag, "_ho_busy"}, {31'd0, bus.busy}, 32'd1);
    step(3);
    check({tag, "_ho3_detrst"}, {31'd0, bus.det_reset}, 32'd1);
    check({tag, "_ho3_busy"}, {31'd0, bus.busy}, 32'd1);
    step();
`ifdef PCM_SEQ_AUTO_REARM_EN
    check({tag, "_end_busy"}, {31'd0, bus.busy}, 32'd1);
    check({tag, "_end_detrst"}, {31'd0, bus.det_reset}, 32'd0);
    model_armed = 1'b1;
`else
    check({tag, "_end_busy"}, {31'd0, bus.busy}, 32'd0);
    check({tag, "_end_detrst"}, {31'd0, bus.det_reset}, 32'd1);
`endif
  endtask

  task automatic do_reset();
    reset = 1'b1;
    step();
    reset = 1'b0;
    model_armed = 1'b0;
  endtask

  initial begin
    vecs[0] = '{mask: 3'b001, t0: 32'd100, t1: 32'd0, t2: 32'd0, first: 8'd0,
                d0: 32'd0, d1: 32'd0, d2: 32'd0, hold: 20};
    vecs[1] = '{mask: 3'b111, t0: 32'd205, t1: 32'd200, t2: 32'd212, first: 8'd1,
                d0: 32'd5, d1: 32'd0, d2: 32'd12, hold: 2};
    vecs[2] = '{mask: 3'b011, t0: 32'hFFFF_FFFE, t1: 32'h0000_0003, t2: 32'd0, first: 8'd0,
                d0: 32'd0, d1: 32'd5, d2: 32'd0, hold: 2};
    vecs[3] = '{mask: 3'b110, t0: 32'd999, t1: 32'd50, t2: 32'd50, first: 8'd1,
                d0: 32'd0, d1: 32'd0, d2: 32'd0, hold: 2};
    vecs[4] = '{mask: 3'b101, t0: 32'd10, t1: 32'd1, t2: 32'h8000_0000, first: 8'd0,
                d0: 32'd0, d1: 32'd0, d2: 32'h7FFF_FFF6, hold: 2};
    vecs[5] = '{mask: 3'b100, t0: 32'd1, t1: 32'd2, t2: 32'd7, first: 8'd2,
                d0: 32'd0, d1: 32'd0, d2: 32'd0, hold: 4};

    reset            = 1'b1;
    bus.start        = 1'b0;
    bus.ch_triggered = 3'd0;
    bus.ch_time      = '0;
    bus.result_ack   = 1'b0;
    step(3);
    check_reset_outputs("por");
    reset = 1'b0;
    step(5);
    check("cnt_run", bus.sample_counter, 32'd5);

    for (int i = 0; i < 6; i++) begin
      run_vector(vecs[i], i);
    end

    // start and trigger in the same IDLE cycle: only the arm happens
    do_reset();
    bus.start        = 1'b1;
    bus.ch_triggered = 3'b001;
    step();
    bus.start        = 1'b0;
    bus.ch_triggered = 3'd0;
    check("st_trg_busy", {31'd0, bus.busy}, 32'd1);
    check("st_trg_detrst", {31'd0, bus.det_reset}, 32'd0);
    step(12);
    check("st_trg_novalid", {31'd0, bus.result_valid}, 32'd0);
    bus.ch_time      = {32'd0, 32'd0, 32'd40};
    bus.ch_triggered = 3'b001;
    step(9);
    check("st_trg_report", {31'd0, bus.result_valid}, 32'd1);
    bus.ch_triggered = 3'd0;

    // reset at WINDOW count 3
    do_reset();
    bus.start = 1'b1;
    step();
    bus.start        = 1'b0;
    bus.ch_time      = {32'd0, 32'd0, 32'd77};
    bus.ch_triggered = 3'b001;
    step(4);
    check("midwin_detrst", {31'd0, bus.det_reset}, 32'd0);
    reset = 1'b1;
    step();
    check_reset_outputs("midwin");
    reset            = 1'b0;
    bus.ch_triggered = 3'd0;
    step();
    check("midwin_cnt1", bus.sample_counter, 32'd1);
    check("midwin_idle", {31'd0, bus.busy}, 32'd0);

    // reset during REPORT clears the held result
    bus.start = 1'b1;
    step();
    bus.start        = 1'b0;
    bus.ch_time      = {32'd3, 32'd5, 32'd0};
    bus.ch_triggered = 3'b110;
    step(9);
    check("midrep_first", {24'd0, bus.result_first}, 32'd2);
    check("midrep_d1", bus.result_delta[63:32], 32'd2);
    bus.ch_triggered = 3'd0;
    reset = 1'b1;
    step();
    check_reset_outputs("midrep");
    reset = 1'b0;
    step(2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/pcm_capture_sequencer.md
PCM_CAPTURE_SEQUENCER -- requirements
Module: pcm_capture_sequencer

Interface
REQ-001 Parameter NUM_CH, default 3: number of peak-detector channels sequenced.
REQ-002 Parameter WINDOW_LEN, default 4800: pcm_clk cycles from first trigger to capture, range 1..2^16-1.
REQ-003 Parameter HOLDOFF_LEN, default 24000: pcm_clk cycles detectors are held in reset after a report, range 1..2^16-1.
REQ-004 pcm_clk  in  1  sample clock; all logic on rising edge.
REQ-005 reset  in  1  synchronous, active-high.
REQ-006 start  in  1  one-cycle arm request, honoured in IDLE only.
REQ-007 ch_triggered  in  NUM_CH  per-channel triggered flag from each detector.
REQ-008 ch_time  in  32*NUM_CH  per-channel triggered_time; channel i occupies bits [32i+31:32i].
REQ-009 result_ack  in  1  consumer accepts the current result.
REQ-010 sample_counter  out  32  free-running sample index shared with all detectors.
REQ-011 det_reset  out  1  reset to all detectors.
REQ-012 busy  out  1  high in every state except IDLE.
REQ-013 result_valid  out  1  result fields valid.
REQ-014 result_mask  out  NUM_CH  channels that triggered by capture.
REQ-015 result_first  out  8  index of earliest channel.
REQ-016 result_delta  out  32*NUM_CH  per-channel time minus earliest time.

Function
REQ-017 sample_counter shall increment by 1 every cycle, wrapping 0xFFFFFFFF->0.
REQ-018 States: IDLE, ARMED, WINDOW, REPORT, HOLDOFF; one state register.
REQ-019 IDLE: det_reset=1; start=1 -> ARMED next cycle.
REQ-020 ARMED: det_reset=0; any ch_triggered bit=1 -> WINDOW with window counter loaded to 0.
REQ-021 WINDOW: det_reset=0; counter increments each cycle; on the cycle counter==WINDOW_LEN-1 -> REPORT, capturing ch_triggered and ch_time into result registers on the same edge.
REQ-022 REPORT: det_reset=1; result_valid=1 from the first REPORT cycle until the cycle result_ack=1 is sampled; then -> HOLDOFF with holdoff counter loaded to 0.
REQ-023 result_valid shall drop on the edge after ack; result fields hold stable while result_valid=1.
REQ-024 HOLDOFF: det_reset=1; on counter==HOLDOFF_LEN-1 -> IDLE.
REQ-025 Earliest channel: triggered channel j minimising time under wrap-safe compare (t_i earlier than t_j iff signed 32-bit (t_i - t_j) < 0); ties -> lowest index.
REQ-026 result_delta[i] = t_i - t_first modulo 2^32 for masked channels; 0 for unmasked channels; result_delta[first]=0.
REQ-027 Earliest/delta computation may be pipelined but result_valid shall not rise until all fields are final; total capture-edge-to-result_valid latency at most NUM_CH+1 cycles, fixed for a given NUM_CH.
REQ-028 start outside IDLE and result_ack outside REPORT shall be ignored.
REQ-029 start and ch_triggered in the same IDLE cycle: only the IDLE->ARMED transition occurs; trigger evaluated from ARMED onward.

Reset
REQ-030 reset=1 shall force state IDLE, sample_counter=0, det_reset=1, busy=0, result_valid=0, result_mask=0, result_first=0, result_delta=0, counters=0, from any state including mid-WINDOW and mid-REPORT.

Configuration
REQ-031 Macro PCM_SEQ_AUTO_REARM_EN defined: HOLDOFF end goes to ARMED directly (busy stays 1); undefined: HOLDOFF end goes to IDLE and waits for start.

Verification (WINDOW_LEN=8, HOLDOFF_LEN=4, NUM_CH=3)
REQ-032 reset, start, ch_triggered=001 with ch_time0=100 at cycle 10 -> REPORT 8 cycles later, mask=001, first=0, delta=0/0/0.
REQ-033 Times ch0=205, ch1=200, ch2=212, all triggered before capture -> first=1, deltas 5,0,12.
REQ-034 ch0=0xFFFFFFFE, ch1=0x00000003 -> first=0, delta1=5 (wrap).
REQ-035 result_ack held low 20 cycles -> result_valid and fields stable 20 cycles; ack -> HOLDOFF 4 cycles det_reset=1, then IDLE (or ARMED with PCM_SEQ_AUTO_REARM_EN).
REQ-036 reset asserted at WINDOW count 3 -> next cycle all outputs at reset values; start ignored while in REPORT.
